// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit path and the receive wrapper.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam logic        UART_IDLE_LEVEL = 1'b1;
    localparam int unsigned UART_BAUD_DIV   = 868;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data.
module sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned AddrW = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] din_i,
    output logic [Width-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned Depth = 2 ** AddrW;

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wptr_q, rptr_q;
    logic [AddrW:0]   count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AddrW + 1)'(Depth));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a fixed-divisor serialiser.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = UART_BAUD_DIV,
    parameter int unsigned FIFO_AW  = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] WriteData,
    input  logic       WriteStrobe,
    input  logic       ClearOverflow,
    output logic       SDO,
    output logic       Busy,
    output logic       FifoFull,
    output logic       FifoEmpty,
    output logic       Overflow
);

    localparam logic [15:0] CntLoad = 16'(BAUD_DIV - 1);
    localparam logic [2:0]  LastBit = 3'(UART_DATA_BITS - 1);

    tx_state_t                 state_q, state_d;
    logic [15:0]               cnt_q, cnt_d;
    logic [2:0]                idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      sdo_q, sdo_d;
    logic                      ovf_q, ovf_d;
    logic                      pop;
    logic [7:0]                fifo_dout;
    logic                      bit_end;

    sync_fifo #(
        .Width (8),
        .AddrW (FIFO_AW)
    ) u_fifo (
        .clk_i   (Clock),
        .rst_i   (Reset),
        .push_i  (WriteStrobe),
        .pop_i   (pop),
        .din_i   (WriteData),
        .dout_o  (fifo_dout),
        .full_o  (FifoFull),
        .empty_o (FifoEmpty)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            sdo_q   <= UART_IDLE_LEVEL;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            sdo_q   <= sdo_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bit_end = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            StIdle: begin
                if (!FifoEmpty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    cnt_d   = CntLoad;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    cnt_d   = CntLoad;
                    idx_d   = '0;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d   = CntLoad;
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LastBit) state_d = StStop;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    // Chain straight into the next start bit when data is waiting.
                    if (!FifoEmpty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        cnt_d   = CntLoad;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        sdo_d = UART_IDLE_LEVEL;
        case (state_d)
            StStart: sdo_d = ~UART_IDLE_LEVEL;
            StData:  sdo_d = shift_d[0];
            default: sdo_d = UART_IDLE_LEVEL;
        endcase
        // A dropped write outranks a coincident clear.
        ovf_d = ovf_q;
        if (ClearOverflow)            ovf_d = 1'b0;
        if (WriteStrobe && FifoFull)  ovf_d = 1'b1;
    end

    assign SDO      = sdo_q;
    assign Overflow = ovf_q;
    assign Busy     = (state_q != StIdle) | ~FifoEmpty;

endmodule
